// File: rtl/word_port_pkg.sv
// ---------------------------------------------------------------------------
// word_port_pkg
//   Shared definitions for the 16-bit word memory port:
//     - state_t        : port sequencer states (IDLE/LO/HI/DONE)
//     - TIMEOUT_CYCLES_DEF : default per-byte MemAck wait limit
//     - LO/HI lane bounds  : byte-lane positions inside a 16-bit word
//     - next_byte_addr()   : 16-bit modulo address increment
// ---------------------------------------------------------------------------
package word_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_CYCLES_DEF = 15;

    // Little-endian lanes: low byte lives at Addr, high byte at Addr+1.
    localparam int LO_LANE_LSB = 0;
    localparam int LO_LANE_MSB = 7;
    localparam int HI_LANE_LSB = 8;
    localparam int HI_LANE_MSB = 15;

    // Wraps at the top of the 64K space (FFFF + 1 = 0000).
    function automatic logic [15:0] next_byte_addr(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/word_memory_port.sv
// ---------------------------------------------------------------------------
// word_memory_port
//   Performs a 16-bit read or write as two sequential byte transfers on a
//   byte-wide request/ack memory bus (low byte at Addr, high byte at Addr+1).
//   All outputs are registered; outputs are computed from the next state.
//
//   Optional feature macro: WORD_PORT_TIMEOUT_EN
//     defined   -> per-byte MemAck wait counter; after TIMEOUT_CYCLES cycles
//                  without MemAck the access ends in DONE with Err=1.
//     undefined -> waits forever for MemAck; Err tied to 0.
//
//   Ports:
//     i_Clock, i_Reset      clock (rising edge), async active-high reset
//     i_Addr, i_Req, i_WE,  request side: word address, start strobe,
//     i_WData               write enable and write data (latched on accept)
//     o_RData, o_Done,      assembled read data, completion pulse,
//     o_Busy, o_Err         busy (state != IDLE), timeout flag
//     o_MemReq, o_MemWE,    byte bus request, write enable,
//     o_MemAddr, o_MemWData byte address, byte write data
//     i_MemRData, i_MemAck  byte read data and completion strobe
// ---------------------------------------------------------------------------
module word_memory_port
    import word_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [15:0] i_Addr,
    input  logic        i_Req,
    input  logic        i_WE,
    input  logic [15:0] i_WData,
    output logic [15:0] o_RData,
    output logic        o_Done,
    output logic        o_Busy,
    output logic        o_Err,
    output logic        o_MemReq,
    output logic        o_MemWE,
    output logic [15:0] o_MemAddr,
    output logic [7:0]  o_MemWData,
    input  logic [7:0]  i_MemRData,
    input  logic        i_MemAck
);

    // A zero limit would time out before the memory could ever answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("word_memory_port: TIMEOUT_CYCLES must be >= 1");
    end

    state_t      r_state,    w_state_nx;
    logic [15:0] r_addr_q,   w_addr_nx;
    logic        r_we_q,     w_we_nx;
    logic [15:0] r_wdata_q,  w_wdata_nx;
    logic [15:0] r_rdata,    w_rdata_nx;
    logic        r_done,     w_done_nx;
    logic        r_busy,     w_busy_nx;
    logic        r_memreq,   w_memreq_nx;
    logic        r_memwe,    w_memwe_nx;
    logic [15:0] r_memaddr,  w_memaddr_nx;
    logic [7:0]  r_memwdata, w_memwdata_nx;

`ifdef WORD_PORT_TIMEOUT_EN
    logic [15:0] r_wait,     w_wait_nx;
    logic        r_err,      w_err_nx;
    // A byte times out on the edge that would complete its
    // TIMEOUT_CYCLES-th cycle without MemAck.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_addr_q   <= '0;
            r_we_q     <= 1'b0;
            r_wdata_q  <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_memreq   <= 1'b0;
            r_memwe    <= 1'b0;
            r_memaddr  <= '0;
            r_memwdata <= '0;
`ifdef WORD_PORT_TIMEOUT_EN
            r_wait     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_addr_q   <= w_addr_nx;
            r_we_q     <= w_we_nx;
            r_wdata_q  <= w_wdata_nx;
            r_rdata    <= w_rdata_nx;
            r_done     <= w_done_nx;
            r_busy     <= w_busy_nx;
            r_memreq   <= w_memreq_nx;
            r_memwe    <= w_memwe_nx;
            r_memaddr  <= w_memaddr_nx;
            r_memwdata <= w_memwdata_nx;
`ifdef WORD_PORT_TIMEOUT_EN
            r_wait     <= w_wait_nx;
            r_err      <= w_err_nx;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next state, latched request and next-cycle output values
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr_q;
        w_we_nx       = r_we_q;
        w_wdata_nx    = r_wdata_q;
        w_rdata_nx    = r_rdata;
        w_done_nx     = 1'b0;
        w_busy_nx     = 1'b0;
        w_memreq_nx   = 1'b0;
        w_memwe_nx    = 1'b0;
        w_memaddr_nx  = r_memaddr;
        w_memwdata_nx = r_memwdata;
`ifdef WORD_PORT_TIMEOUT_EN
        w_wait_nx     = r_wait;
        w_err_nx      = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_Req) begin
                    w_addr_nx  = i_Addr;
                    w_we_nx    = i_WE;
                    w_wdata_nx = i_WData;
                    w_state_nx = ST_LO;
`ifdef WORD_PORT_TIMEOUT_EN
                    w_wait_nx  = '0;
`endif
                end
            end

            ST_LO: begin
                if (i_MemAck) begin
                    if (!r_we_q)
                        w_rdata_nx[LO_LANE_MSB:LO_LANE_LSB] = i_MemRData;
                    w_state_nx = ST_HI;
`ifdef WORD_PORT_TIMEOUT_EN
                    w_wait_nx  = '0;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nx = ST_DONE;
                    w_err_nx   = 1'b1;
                end else begin
                    w_wait_nx  = r_wait + 16'd1;
`endif
                end
            end

            ST_HI: begin
                if (i_MemAck) begin
                    if (!r_we_q)
                        w_rdata_nx[HI_LANE_MSB:HI_LANE_LSB] = i_MemRData;
                    w_state_nx = ST_DONE;
`ifdef WORD_PORT_TIMEOUT_EN
                end else if (r_wait == WAIT_LAST) begin
                    // Low byte already captured on a read stays in RData.
                    w_state_nx = ST_DONE;
                    w_err_nx   = 1'b1;
                end else begin
                    w_wait_nx  = r_wait + 16'd1;
`endif
                end
            end

            ST_DONE: begin
                w_state_nx = ST_IDLE;
`ifdef WORD_PORT_TIMEOUT_EN
                w_err_nx   = 1'b0;
`endif
            end

            default: w_state_nx = ST_IDLE;
        endcase

        // Outputs are a function of the state being entered so that they
        // line up with the state during the following cycle.
        w_busy_nx = (w_state_nx != ST_IDLE);
        w_done_nx = (w_state_nx == ST_DONE);
        case (w_state_nx)
            ST_LO: begin
                w_memreq_nx   = 1'b1;
                w_memwe_nx    = w_we_nx;
                w_memaddr_nx  = w_addr_nx;
                w_memwdata_nx = w_wdata_nx[LO_LANE_MSB:LO_LANE_LSB];
            end
            ST_HI: begin
                w_memreq_nx   = 1'b1;
                w_memwe_nx    = w_we_nx;
                w_memaddr_nx  = next_byte_addr(w_addr_nx);
                w_memwdata_nx = w_wdata_nx[HI_LANE_MSB:HI_LANE_LSB];
            end
            default: ;
        endcase
    end

    assign o_RData    = r_rdata;
    assign o_Done     = r_done;
    assign o_Busy     = r_busy;
    assign o_MemReq   = r_memreq;
    assign o_MemWE    = r_memwe;
    assign o_MemAddr  = r_memaddr;
    assign o_MemWData = r_memwdata;
`ifdef WORD_PORT_TIMEOUT_EN
    assign o_Err      = r_err;
`else
    assign o_Err      = 1'b0;
`endif

endmodule

// File: tb/tb_word_memory_port.sv
// ---------------------------------------------------------------------------
// tb_word_memory_port
//   Bench for word_memory_port. The bench plays the byte memory (a sparse
//   byte array with random contents) and predicts each access from the
//   little-endian word rules: byte addresses Addr and Addr+1, expected
//   RData = {mem[Addr+1], mem[Addr]} on reads, unchanged on writes.
// ---------------------------------------------------------------------------
module tb_word_memory_port;

    localparam int TO = 4;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic [15:0] i_Addr;
    logic        i_Req;
    logic        i_WE;
    logic [15:0] i_WData;
    logic [15:0] o_RData;
    logic        o_Done;
    logic        o_Busy;
    logic        o_Err;
    logic        o_MemReq;
    logic        o_MemWE;
    logic [15:0] o_MemAddr;
    logic [7:0]  o_MemWData;
    logic [7:0]  i_MemRData;
    logic        i_MemAck;

    word_memory_port #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Addr    (i_Addr),
        .i_Req     (i_Req),
        .i_WE      (i_WE),
        .i_WData   (i_WData),
        .o_RData   (o_RData),
        .o_Done    (o_Done),
        .o_Busy    (o_Busy),
        .o_Err     (o_Err),
        .o_MemReq  (o_MemReq),
        .o_MemWE   (o_MemWE),
        .o_MemAddr (o_MemAddr),
        .o_MemWData(o_MemWData),
        .i_MemRData(i_MemRData),
        .i_MemAck  (i_MemAck)
    );

    always #5 i_Clock = ~i_Clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  mem [logic [15:0]];
    logic [15:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic touch(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
    endtask

    // Idle-cycle check: nothing in flight, RData holding.
    task automatic chk_idle(input string tag);
        chk({tag, ".done"},   32'(o_Done),   32'd0);
        chk({tag, ".busy"},   32'(o_Busy),   32'd0);
        chk({tag, ".memreq"}, 32'(o_MemReq), 32'd0);
        chk({tag, ".rdata"},  32'(o_RData),  32'(exp_rdata));
    endtask

    // One full word access. Called #1 after a rising edge with the port idle.
    // w0/w1: wait cycles before MemAck on the low/high byte.
    // busy_req: hammer Req with Addr=0300 during the high-byte phase.
    task automatic run_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                              input int w0, input int w1, input bit busy_req);
        logic [15:0] ba [2];
        logic [7:0]  bd [2];
        int          wt [2];
        ba[0] = a;          ba[1] = a + 16'd1;
        bd[0] = wd[7:0];    bd[1] = wd[15:8];
        wt[0] = w0;         wt[1] = w1;
        touch(ba[0]);
        touch(ba[1]);

        i_Addr = a; i_WE = we; i_WData = wd; i_Req = 1'b1;
        @(posedge i_Clock); #1;
        // Scramble the request inputs: the port must have latched them.
        i_Req = 1'b0; i_Addr = 16'($urandom); i_WE = 1'($urandom); i_WData = 16'($urandom);

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w <= wt[k]; w++) begin
                chk("memreq", 32'(o_MemReq),  32'd1);
                chk("memaddr", 32'(o_MemAddr), 32'(ba[k]));
                chk("memwe",  32'(o_MemWE),   32'(we));
                if (we) chk("memwdata", 32'(o_MemWData), 32'(bd[k]));
                chk("busy",   32'(o_Busy),    32'd1);
                chk("done_early", 32'(o_Done), 32'd0);
                i_MemAck   = (w == wt[k]);
                i_MemRData = (w == wt[k] && !we) ? mem[ba[k]] : 8'($urandom);
                if (k == 1 && busy_req) begin
                    i_Req = 1'b1; i_Addr = 16'h0300; i_WE = 1'($urandom);
                end
                @(posedge i_Clock); #1;
                i_MemAck = 1'b0;
                i_Req    = 1'b0;
                if (w == wt[k]) begin
                    if (we) mem[ba[k]] = bd[k];
                    else if (k == 0) exp_rdata[7:0] = mem[ba[k]];
                    else exp_rdata[15:8] = mem[ba[k]];
                end
            end
        end

        // DONE cycle; a stray MemAck here must be ignored.
        chk("done",        32'(o_Done),   32'd1);
        chk("done.busy",   32'(o_Busy),   32'd1);
        chk("done.memreq", 32'(o_MemReq), 32'd0);
        chk("done.err",    32'(o_Err),    32'd0);
        chk("done.rdata",  32'(o_RData),  32'(exp_rdata));
        i_MemAck = 1'($urandom);
        @(posedge i_Clock); #1;
        i_MemAck = 1'b0;
        chk_idle("post");
    endtask

    initial begin
        i_Reset = 1'b1; i_Addr = '0; i_Req = 1'b0; i_WE = 1'b0; i_WData = '0;
        i_MemRData = '0; i_MemAck = 1'b0;
        exp_rdata = '0;
        #3;
        chk("rst.rdata",   32'(o_RData),    32'd0);
        chk("rst.done",    32'(o_Done),     32'd0);
        chk("rst.busy",    32'(o_Busy),     32'd0);
        chk("rst.err",     32'(o_Err),      32'd0);
        chk("rst.memreq",  32'(o_MemReq),   32'd0);
        chk("rst.memwe",   32'(o_MemWE),    32'd0);
        chk("rst.memaddr", 32'(o_MemAddr),  32'd0);
        chk("rst.memwd",   32'(o_MemWData), 32'd0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(posedge i_Clock); #1;
        // MemAck while idle must not start anything.
        i_MemAck = 1'b1;
        @(posedge i_Clock); #1;
        i_MemAck = 1'b0;
        chk_idle("idle_ack");

        // Zero-wait read: 0100=34, 0101=12 -> 1234.
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        run_access(16'h0100, 1'b0, 16'h0000, 0, 0, 1'b0);
        chk("read0100", 32'(o_RData), 32'h1234);

        // Write with two wait cycles per byte; RData must not move.
        run_access(16'h2000, 1'b1, 16'hBEEF, 2, 2, 1'b0);
        chk("wr.lo", 32'(mem[16'h2000]), 32'hEF);
        chk("wr.hi", 32'(mem[16'h2001]), 32'hBE);
        chk("wr.rdata_kept", 32'(o_RData), 32'h1234);

        // Wrap-around read: second byte at 0000.
        mem[16'hFFFF] = 8'hA5;
        mem[16'h0000] = 8'h5A;
        run_access(16'hFFFF, 1'b0, 16'h0000, 1, 0, 1'b0);
        chk("wrap", 32'(o_RData), 32'h5AA5);

        // Req while busy is dropped; back-to-back accesses follow.
        run_access(16'h1234, 1'b0, 16'h0000, 0, 2, 1'b1);
        run_access(16'h0500, 1'b1, 16'hCAFE, 1, 1, 1'b1);

        // Reset during the high-byte phase.
        touch(16'h4000); touch(16'h4001);
        i_Addr = 16'h4000; i_WE = 1'b0; i_Req = 1'b1;
        @(posedge i_Clock); #1;
        i_Req = 1'b0; i_MemAck = 1'b1; i_MemRData = mem[16'h4000];
        @(posedge i_Clock); #1;
        i_MemAck = 1'b0;
        chk("rstmid.in_hi", 32'(o_MemAddr), 32'h4001);
        #2 i_Reset = 1'b1;
        #1;
        exp_rdata = '0;
        chk_idle("rstmid");
        #1 i_Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_MemAck = 1'($urandom);
            @(posedge i_Clock); #1;
            chk_idle("rstmid.after");
        end
        i_MemAck = 1'b0;
        run_access(16'h4000, 1'b0, 16'h0000, 0, 0, 1'b0);

`ifdef WORD_PORT_TIMEOUT_EN
        // No MemAck at all: LO for TO cycles, then DONE with Err.
        i_Addr = 16'h6000; i_WE = 1'b0; i_Req = 1'b1;
        @(posedge i_Clock); #1;
        i_Req = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to.memreq", 32'(o_MemReq), 32'd1);
            chk("to.done",   32'(o_Done),   32'd0);
            @(posedge i_Clock); #1;
        end
        chk("to.done_pulse", 32'(o_Done),   32'd1);
        chk("to.err",        32'(o_Err),    32'd1);
        chk("to.memreq_off", 32'(o_MemReq), 32'd0);
        chk("to.rdata",      32'(o_RData),  32'(exp_rdata));
        @(posedge i_Clock); #1;
        chk("to.err_clr", 32'(o_Err), 32'd0);
        chk_idle("to.post");
`endif

        // Randomized accesses, biased toward the wrap address.
        for (int n = 0; n < 24; n++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_access(ra, 1'($urandom), 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_memory_port.md
Name: word_memory_port

Overview:
- Consumer end of the address path: accepts a 16-bit address from the address register file's memory-address output, plus a request.
- Performs a 16-bit read or write as two sequential byte transfers on an 8-bit memory handshake bus.
- Little-endian: low byte at Addr, high byte at Addr+1.
- Sits between the address register file / ALU data path and the byte-wide memory.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles to wait for MemAck per byte. Used only when WORD_PORT_TIMEOUT_EN is defined.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Addr  input  16  word address from the address register file
- Req  input  1  start request; sampled only in IDLE
- WE  input  1  1 = write, 0 = read; latched with Req
- WData  input  16  write data; latched with Req
- RData  output  16  assembled read data; valid while Done=1, held until the next read completes
- Done  output  1  one-cycle completion pulse
- Busy  output  1  high whenever state != IDLE
- Err  output  1  timeout flag, valid with Done; constant 0 without the macro
- MemReq  output  1  byte transfer request
- MemWE  output  1  byte write enable
- MemAddr  output  16  byte address
- MemWData  output  8  byte write data
- MemRData  input  8  byte read data, valid in the MemAck cycle
- MemAck  input  1  memory completion strobe, one per transfer

Behaviour:
- Reset (async): state=IDLE; addr_q, wdata_q, RData, MemAddr, MemWData = 0; Done, Busy, Err, MemReq, MemWE = 0.
- Reset mid-operation aborts the access immediately, with no Done pulse.
- States: IDLE, LO, HI, DONE; all outputs are registered.
- IDLE: on an edge with Req=1, latch Addr, WE, WData and go to LO. Req=0 stays in IDLE.
- LO: MemReq=1, MemAddr=addr_q, MemWE=we_q, MemWData=wdata_q[7:0].
  - Edge with MemAck=1 → go to HI; on a read, capture MemRData into RData[7:0].
- HI: MemReq=1, MemAddr=addr_q+1, MemWE=we_q, MemWData=wdata_q[15:8].
  - Edge with MemAck=1 → go to DONE; on a read, capture into RData[15:8].
- Address increment is 16-bit modulo: 16'hFFFF + 1 = 16'h0000.
- DONE: Done=1, MemReq=0, then IDLE on the next edge. Back-to-back Req is accepted one cycle after DONE.
- Latency with zero-wait memory (MemAck high in the first MemReq cycle):
  - Req sampled at edge 0; LO during cycle 1; HI during cycle 2; Done high during cycle 3.
  - Each wait cycle (MemAck low in LO/HI) adds one cycle.
- Req while Busy is ignored, not queued. Changes to Addr/WE/WData after acceptance have no effect.
- MemAck in IDLE or DONE is ignored.
- RData is updated only by reads. A write leaves RData unchanged.

Optional Feature:
- Macro: WORD_PORT_TIMEOUT_EN.
- Defined:
  - A per-byte wait counter clears on entry to LO/HI and increments each cycle without MemAck.
  - When the counter reaches TIMEOUT_CYCLES with no MemAck, go to DONE with Err=1 and drop MemReq.
  - RData is left partially updated; the bytes already acked stay written.
  - Err clears on leaving DONE.
- Not defined: no counter; the port waits forever for MemAck; Err is tied to 0.

Decomposition:
- Shared package word_port_pkg holds:
  - state encodings (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3);
  - TIMEOUT_CYCLES default;
  - byte-lane constants LO_LANE=[7:0] and HI_LANE=[15:8].
- No sub-module is needed. The optional timeout counter stays inline under the macro.

Test Plan:
- Read, zero-wait: memory 16'h0100=8'h34, 16'h0101=8'h12; Addr=16'h0100, Req, WE=0 → MemAddr 0100 then 0101; Done in cycle 3; RData=16'h1234.
- Write with wait states: Addr=16'h2000, WData=16'hBEEF, WE=1; MemAck delayed 2 cycles per byte → 8'hEF written at 2000, 8'hBE at 2001; Done in cycle 7; RData unchanged.
- Wrap-around: read at Addr=16'hFFFF → second byte at MemAddr=16'h0000; RData={mem[0000],mem[FFFF]}.
- Req while Busy: second Req with Addr=16'h0300 during HI → ignored; MemAddr never shows 0300; exactly one Done.
- Reset in HI: assert Reset → MemReq=0, Busy=0, Done=0 immediately; no Done pulse; a subsequent read completes normally.
- With WORD_PORT_TIMEOUT_EN and TIMEOUT_CYCLES=4: MemAck never asserted → Done=1 and Err=1 after 4 LO wait cycles; MemReq drops.
